// File: rtl/mode_pipe_pkg.sv
// Shared types and constants for the mode pipe checker slice.
package mode_pipe_pkg;

  // Checker FSM states; DONE and FAIL are absorbing until reset.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } state_e;

  // First-error cause codes reported on err_code_o.
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FIELD = 2'd1;
  localparam logic [1:0] ERR_SEQ   = 2'd2;
  localparam logic [1:0] ERR_DELAY = 2'd3;

  // When several causes fire in one cycle the lowest nonzero code wins.
  function automatic logic [1:0] pick_code(input logic fld_err,
                                           input logic seq_err,
                                           input logic dly_err);
    logic [1:0] code;
    if (fld_err) begin
      code = ERR_FIELD;
    end else if (seq_err) begin
      code = ERR_SEQ;
    end else if (dly_err) begin
      code = ERR_DELAY;
    end else begin
      code = ERR_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/mode_pipe_checker_if.sv
// Bundle of the mode stream, field-register and status signals of the checker.
interface mode_pipe_checker_if #(
  parameter int WIDTH   = 8,
  parameter int FIELD_W = 5
) ();

  logic [WIDTH-1:0]   mode_i;
  logic               mode_vld_i;
  logic               fld_we_i;
  logic [FIELD_W-1:0] fld_mask_i;
  logic [FIELD_W-1:0] fld_data_i;
  logic               fld_chk_i;
  logic [FIELD_W-1:0] fld_exp_i;
  logic [WIDTH-1:0]   mode_d_o;
  logic               mode_d_vld_o;
  logic [FIELD_W-1:0] fld_o;
  logic               done_o;
  logic               err_o;
  logic [1:0]         err_code_o;

  // Stimulus side: drives the stream and field commands, observes status.
  modport master (
    output mode_i, mode_vld_i, fld_we_i, fld_mask_i, fld_data_i, fld_chk_i, fld_exp_i,
    input  mode_d_o, mode_d_vld_o, fld_o, done_o, err_o, err_code_o
  );

  // Checker side.
  modport slave (
    input  mode_i, mode_vld_i, fld_we_i, fld_mask_i, fld_data_i, fld_chk_i, fld_exp_i,
    output mode_d_o, mode_d_vld_o, fld_o, done_o, err_o, err_code_o
  );

endinterface

// File: rtl/mode_delay_line.sv
// Valid-tagged shift pipe: every cycle (bubbles included) moves one stage on.
module mode_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_vld_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_vld_o
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  // Next pipe contents; data of an invalid entry is forced to zero on entry.
  always_comb begin
    vld_d = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = {WIDTH{1'b0}};
    end
    if (in_vld_i) begin
      data_d[0] = in_data_i;
    end else begin
      data_d[0] = {WIDTH{1'b0}};
    end
    vld_d[0] = in_vld_i;
    for (int i = 1; i < DEPTH; i++) begin
      data_d[i] = data_q[i-1];
      vld_d[i]  = vld_q[i-1];
    end
  end

  // Pipe registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= {WIDTH{1'b0}};
      end
      vld_q <= {DEPTH{1'b0}};
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign out_data_o = data_q[DEPTH-1];
  assign out_vld_o  = vld_q[DEPTH-1];

endmodule

// File: rtl/mode_pipe_checker.sv
// Consumes the regression mode counter: delays it, keeps a masked field
// register and runs a sticky pass/fail checker over the stream.
module mode_pipe_checker
  import mode_pipe_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 3,
  parameter int FIELD_W  = 5,
  parameter int END_MODE = 4
) (
  input  logic           clk,
  input  logic           reset_l,
  mode_pipe_checker_if.slave bus
);

  if ((DEPTH < 1) || (DEPTH > 8)) begin : g_bad_depth
    $error("mode_pipe_checker: DEPTH must be in 1..8");
  end
  if (END_MODE < DEPTH) begin : g_bad_end
    $error("mode_pipe_checker: END_MODE must not be below DEPTH");
  end

  // END_MODE is kept 32 bits wide so a value beyond the mode range never matches.
  localparam logic [31:0]      END_MODE_L = END_MODE;
  localparam logic [WIDTH-1:0] EXP_DLY    = WIDTH'(END_MODE - DEPTH);
  localparam logic [WIDTH-1:0] ONE_W      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]   dly_data_s;
  logic               dly_vld_s;
  logic [FIELD_W-1:0] fld_q, fld_d;
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   last_q, last_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic               fld_err_s;
  logic               seq_err_s;
  logic               dly_err_s;
  logic               end_hit_s;
  logic [1:0]         code_s;

  mode_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_dly (
    .clk        (clk),
    .reset_l    (reset_l),
    .in_data_i  (bus.mode_i),
    .in_vld_i   (bus.mode_vld_i),
    .out_data_o (dly_data_s),
    .out_vld_o  (dly_vld_s)
  );

  // Masked partial write: only masked bits take the new data.
  always_comb begin
    fld_d = fld_q;
    if (bus.fld_we_i) begin
      fld_d = (fld_q & ~bus.fld_mask_i) | (bus.fld_data_i & bus.fld_mask_i);
    end else begin
      fld_d = fld_q;
    end
  end

  // Checker next state; field compare uses the value before this cycle's write.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    done_d    = done_q;
    err_d     = err_q;
    code_d    = code_q;
    fld_err_s = 1'b0;
    seq_err_s = 1'b0;
    dly_err_s = 1'b0;
    end_hit_s = 1'b0;
    case (state_q)
      IDLE: begin
        fld_err_s = bus.fld_chk_i && (fld_q != bus.fld_exp_i);
        if (bus.mode_vld_i) begin
          seq_err_s = (bus.mode_i != {WIDTH{1'b0}});
          last_d    = bus.mode_i;
        end else begin
          seq_err_s = 1'b0;
        end
      end
      RUN: begin
        fld_err_s = bus.fld_chk_i && (fld_q != bus.fld_exp_i);
        if (bus.mode_vld_i) begin
          seq_err_s = (bus.mode_i != (last_q + ONE_W));
          end_hit_s = (32'(bus.mode_i) == END_MODE_L);
          dly_err_s = end_hit_s && !(dly_vld_s && (dly_data_s == EXP_DLY));
          last_d    = bus.mode_i;
        end else begin
          seq_err_s = 1'b0;
        end
      end
      default: begin
        fld_err_s = 1'b0;
      end
    endcase
    code_s = pick_code(fld_err_s, seq_err_s, dly_err_s);
    if (code_s != ERR_NONE) begin
      state_d = FAIL;
      err_d   = 1'b1;
      code_d  = code_s;
    end else if (end_hit_s) begin
      state_d = DONE;
      done_d  = 1'b1;
    end else if ((state_q == IDLE) && bus.mode_vld_i) begin
      state_d = RUN;
    end else begin
      state_d = state_q;
    end
  end

  // Field register and checker state with registered status outputs.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      fld_q   <= {FIELD_W{1'b0}};
      state_q <= IDLE;
      last_q  <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      fld_q   <= fld_d;
      state_q <= state_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign bus.mode_d_o     = dly_data_s;
  assign bus.mode_d_vld_o = dly_vld_s;
  assign bus.fld_o        = fld_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
  assign bus.err_code_o   = code_q;

endmodule

// File: tb/tb_mode_pipe_checker.sv
// Self-checking bench for mode_pipe_checker: directed scenarios plus a
// randomized run against a behavioural model of the checker rules.
module tb_mode_pipe_checker;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 3;
  localparam int FIELD_W  = 5;
  localparam int END_MODE = 4;

  logic clk = 1'b0;
  logic reset_l;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mode_pipe_checker_if #(.WIDTH(WIDTH), .FIELD_W(FIELD_W)) bus ();
  mode_pipe_checker_if #(.WIDTH(WIDTH), .FIELD_W(FIELD_W)) bus2 ();

  mode_pipe_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIELD_W(FIELD_W), .END_MODE(END_MODE))
    dut (.clk(clk), .reset_l(reset_l), .bus(bus));

  // END_MODE beyond the 8-bit range: the final check never fires, so wrap can be exercised.
  mode_pipe_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIELD_W(FIELD_W), .END_MODE(256))
    dut2 (.clk(clk), .reset_l(reset_l), .bus(bus2));

  // ---------------- behavioural model of dut ----------------
  bit          m_started, m_decided, m_done, m_err;
  int          m_last, m_code;
  logic [4:0]  m_fld;
  int          pq_v[$];
  int          pq_d[$];

  task automatic model_reset();
    m_started = 0; m_decided = 0; m_done = 0; m_err = 0;
    m_last = 0; m_code = 0; m_fld = 5'd0;
    pq_v.delete(); pq_d.delete();
    for (int i = 0; i < DEPTH; i++) begin
      pq_v.push_back(0); pq_d.push_back(0);
    end
  endtask

  task automatic model_step(input bit vld, input int mode, input bit we,
                            input logic [4:0] mask, input logic [4:0] data,
                            input bit chk, input logic [4:0] exp);
    int c;
    int want;
    if (!m_decided) begin
      c = 0;
      if (chk && (m_fld != exp)) c = 1;
      if (vld) begin
        want = m_started ? ((m_last + 1) % 256) : 0;
        if (c == 0 && mode != want) c = 2;
        if (c == 0 && m_started && mode == END_MODE &&
            !(pq_v[0] == 1 && pq_d[0] == END_MODE - DEPTH)) c = 3;
      end
      if (c != 0) begin
        m_decided = 1; m_err = 1; m_code = c;
      end else if (vld && m_started && mode == END_MODE) begin
        m_decided = 1; m_done = 1;
      end
      if (vld) begin
        m_started = 1; m_last = mode;
      end
    end
    if (we) m_fld = (m_fld & ~mask) | (data & mask);
    void'(pq_v.pop_front()); void'(pq_d.pop_front());
    pq_v.push_back(vld ? 1 : 0);
    pq_d.push_back(vld ? mode : 0);
  endtask

  // One clock of stimulus on dut; returns 1 ns after the rising edge.
  task automatic cyc(input bit vld, input int mode, input bit we,
                     input logic [4:0] mask, input logic [4:0] data,
                     input bit chk, input logic [4:0] exp);
    bus.mode_vld_i = vld;
    bus.mode_i     = 8'(mode);
    bus.fld_we_i   = we;
    bus.fld_mask_i = mask;
    bus.fld_data_i = data;
    bus.fld_chk_i  = chk;
    bus.fld_exp_i  = exp;
    model_step(vld, mode, we, mask, data, chk, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mode_vld_i = 1'b0; bus.mode_i = 8'd0; bus.fld_we_i = 1'b0;
    bus.fld_mask_i = 5'd0; bus.fld_data_i = 5'd0; bus.fld_chk_i = 1'b0; bus.fld_exp_i = 5'd0;
    bus2.mode_vld_i = 1'b0; bus2.mode_i = 8'd0; bus2.fld_we_i = 1'b0;
    bus2.fld_mask_i = 5'd0; bus2.fld_data_i = 5'd0; bus2.fld_chk_i = 1'b0; bus2.fld_exp_i = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_l = 1'b0;
    #2;
    reset_l = 1'b1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset_l = 1'b0;
    #3;
    n_cmp++; if (bus.mode_d_vld_o !== 1'b0 || bus.mode_d_o !== 8'd0) begin n_bad++; $display("FAIL reset_pipe: got vld=%b d=%0d expected 0/0", bus.mode_d_vld_o, bus.mode_d_o); end
    n_cmp++; if (bus.fld_o !== 5'd0) begin n_bad++; $display("FAIL reset_fld: got %b expected 00000", bus.fld_o); end
    n_cmp++; if ({bus.done_o, bus.err_o, bus.err_code_o} !== 4'd0) begin n_bad++; $display("FAIL reset_status: got done=%b err=%b code=%0d expected 0/0/0", bus.done_o, bus.err_o, bus.err_code_o); end
    reset_l = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_cmp++; if ({bus.done_o, bus.err_o, bus.err_code_o, bus.mode_d_vld_o} !== 5'd0) begin n_bad++; $display("FAIL reset_idle_edge: got done=%b err=%b code=%0d vld=%b expected all 0", bus.done_o, bus.err_o, bus.err_code_o, bus.mode_d_vld_o); end
  endtask

  task automatic test_pass_stream();
    do_reset();
    for (int m = 0; m < 4; m++) cyc(1'b1, m, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    n_cmp++; if (bus.mode_d_vld_o !== 1'b1 || bus.mode_d_o !== 8'd1) begin n_bad++; $display("FAIL pass_delay_at_end: got vld=%b d=%0d expected 1/1", bus.mode_d_vld_o, bus.mode_d_o); end
    cyc(1'b1, 4, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    n_cmp++; if (bus.done_o !== 1'b1 || bus.err_o !== 1'b0 || bus.err_code_o !== 2'd0) begin n_bad++; $display("FAIL pass_done: got done=%b err=%b code=%0d expected 1/0/0", bus.done_o, bus.err_o, bus.err_code_o); end
    cyc(1'b1, 9, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7);
    n_cmp++; if (bus.done_o !== 1'b1 || bus.err_o !== 1'b0) begin n_bad++; $display("FAIL pass_absorbing: got done=%b err=%b expected 1/0", bus.done_o, bus.err_o); end
  endtask

  task automatic test_bubble_delay();
    do_reset();
    cyc(1'b1, 0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    cyc(1'b1, 1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    cyc(1'b1, 2, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    cyc(1'b0, 77, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    cyc(1'b1, 3, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    n_cmp++; if (bus.mode_d_vld_o !== 1'b1 || bus.mode_d_o !== 8'd2) begin n_bad++; $display("FAIL bubble_delay_val: got vld=%b d=%0d expected 1/2", bus.mode_d_vld_o, bus.mode_d_o); end
    n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL bubble_no_seq_err: got err=%b expected 0", bus.err_o); end
    cyc(1'b1, 4, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    n_cmp++; if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'd3 || bus.done_o !== 1'b0) begin n_bad++; $display("FAIL bubble_delay_err: got done=%b err=%b code=%0d expected 0/1/3", bus.done_o, bus.err_o, bus.err_code_o); end
    n_cmp++; if (bus.mode_d_vld_o !== 1'b0 || bus.mode_d_o !== 8'd0) begin n_bad++; $display("FAIL bubble_zero_data: got vld=%b d=%0d expected 0/0", bus.mode_d_vld_o, bus.mode_d_o); end
  endtask

  task automatic test_field();
    do_reset();
    cyc(1'b0, 0, 1'b1, 5'b11000, 5'b11000, 1'b0, 5'd0);
    cyc(1'b0, 0, 1'b1, 5'b00100, 5'b00100, 1'b0, 5'd0);
    cyc(1'b0, 0, 1'b1, 5'b00011, 5'b00010, 1'b0, 5'd0);
    cyc(1'b0, 0, 1'b1, 5'b01000, 5'b00000, 1'b0, 5'd0);
    n_cmp++; if (bus.fld_o !== 5'b10110) begin n_bad++; $display("FAIL field_accum: got %b expected 10110", bus.fld_o); end
    cyc(1'b0, 0, 1'b1, 5'b11111, 5'b11111, 1'b1, 5'b10110);
    n_cmp++; if (bus.err_o !== 1'b0 || bus.fld_o !== 5'b11111) begin n_bad++; $display("FAIL field_same_cycle_write: got err=%b fld=%b expected 0/11111", bus.err_o, bus.fld_o); end
    cyc(1'b0, 0, 1'b1, 5'b11111, 5'b10110, 1'b0, 5'd0);
    cyc(1'b0, 0, 1'b0, 5'd0, 5'd0, 1'b1, 5'b10111);
    n_cmp++; if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'd1) begin n_bad++; $display("FAIL field_mismatch: got err=%b code=%0d expected 1/1", bus.err_o, bus.err_code_o); end
    cyc(1'b0, 0, 1'b1, 5'b00001, 5'b00001, 1'b0, 5'd0);
    n_cmp++; if (bus.fld_o !== 5'b10111) begin n_bad++; $display("FAIL field_after_fail: got %b expected 10111", bus.fld_o); end
  endtask

  task automatic test_seq_break();
    do_reset();
    cyc(1'b1, 0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    cyc(1'b1, 1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    n_cmp++; if (bus.err_o !== 1'b0) begin n_bad++; $display("FAIL seq_before_break: got err=%b expected 0", bus.err_o); end
    cyc(1'b1, 3, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    n_cmp++; if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'd2) begin n_bad++; $display("FAIL seq_break: got err=%b code=%0d expected 1/2", bus.err_o, bus.err_code_o); end
    cyc(1'b1, 4, 1'b0, 5'd0, 5'd0, 1'b1, 5'b00001);
    n_cmp++; if (bus.err_code_o !== 2'd2 || bus.done_o !== 1'b0) begin n_bad++; $display("FAIL seq_code_sticky: got code=%0d done=%b expected 2/0", bus.err_code_o, bus.done_o); end
    do_reset();
    cyc(1'b1, 1, 1'b0, 5'd0, 5'd0, 1'b1, 5'b00001);
    n_cmp++; if (bus.err_code_o !== 2'd1) begin n_bad++; $display("FAIL simultaneous_lowest: got code=%0d expected 1", bus.err_code_o); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc(1'b1, 0, 1'b1, 5'b11111, 5'b10101, 1'b0, 5'd0);
    cyc(1'b1, 1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    cyc(1'b1, 2, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    n_cmp++; if (bus.fld_o !== 5'b10101 || bus.mode_d_vld_o !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got fld=%b vld=%b expected 10101/1", bus.fld_o, bus.mode_d_vld_o); end
    reset_l = 1'b0;
    #1;
    n_cmp++; if (bus.fld_o !== 5'd0 || bus.mode_d_vld_o !== 1'b0 || bus.mode_d_o !== 8'd0 || {bus.done_o, bus.err_o, bus.err_code_o} !== 4'd0) begin n_bad++; $display("FAIL midrst_async: got fld=%b vld=%b d=%0d done=%b err=%b code=%0d expected all 0", bus.fld_o, bus.mode_d_vld_o, bus.mode_d_o, bus.done_o, bus.err_o, bus.err_code_o); end
    #1;
    reset_l = 1'b1;
    model_reset();
    cyc(1'b1, 5, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    n_cmp++; if (bus.err_o !== 1'b1 || bus.err_code_o !== 2'd2) begin n_bad++; $display("FAIL midrst_restart5: got err=%b code=%0d expected 1/2", bus.err_o, bus.err_code_o); end
    do_reset();
    for (int m = 0; m <= 4; m++) cyc(1'b1, m, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0);
    n_cmp++; if (bus.done_o !== 1'b1 || bus.err_o !== 1'b0) begin n_bad++; $display("FAIL midrst_restart0: got done=%b err=%b expected 1/0", bus.done_o, bus.err_o); end
  endtask

  task automatic test_wrap();
    int bad_seen;
    do_reset();
    bad_seen = 0;
    for (int i = 0; i < 262; i++) begin
      bus2.mode_vld_i = 1'b1;
      bus2.mode_i     = 8'(i % 256);
      @(posedge clk); #1;
      if (i >= DEPTH - 1) begin
        n_cmp++;
        if (bus2.err_o !== 1'b0 || bus2.mode_d_vld_o !== 1'b1 || bus2.mode_d_o !== 8'((i - DEPTH + 1) % 256)) begin
          n_bad++;
          if (bad_seen < 3) $display("FAIL wrap_step%0d: got err=%b code=%0d vld=%b d=%0d expected 0/-/1/%0d", i, bus2.err_o, bus2.err_code_o, bus2.mode_d_vld_o, bus2.mode_d_o, (i - DEPTH + 1) % 256);
          bad_seen++;
        end
      end
    end
    n_cmp++; if (bus2.done_o !== 1'b0) begin n_bad++; $display("FAIL wrap_no_done: got %b expected 0", bus2.done_o); end
    bus2.mode_vld_i = 1'b0;
  endtask

  task automatic test_random();
    bit         vld, we, chk;
    int         mode;
    logic [4:0] mask, data, exp;
    for (int run = 0; run < 6; run++) begin
      do_reset();
      for (int k = 0; k < 60; k++) begin
        vld  = ($urandom_range(0, 3) != 0);
        mode = m_started ? ((m_last + 1) % 256) : 0;
        if ($urandom_range(0, 24) == 0) mode = int'($urandom_range(0, 255));
        we   = ($urandom_range(0, 2) == 0);
        mask = 5'($urandom_range(0, 31));
        data = 5'($urandom_range(0, 31));
        chk  = ($urandom_range(0, 3) == 0);
        exp  = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : m_fld;
        cyc(vld, mode, we, mask, data, chk, exp);
        n_cmp++; if (bus.mode_d_vld_o !== pq_v[0][0] || bus.mode_d_o !== 8'(pq_d[0])) begin n_bad++; $display("FAIL rnd_pipe r%0d c%0d: got vld=%b d=%0d expected %0d/%0d", run, k, bus.mode_d_vld_o, bus.mode_d_o, pq_v[0], pq_d[0]); end
        n_cmp++; if (bus.fld_o !== m_fld) begin n_bad++; $display("FAIL rnd_fld r%0d c%0d: got %b expected %b", run, k, bus.fld_o, m_fld); end
        n_cmp++; if (bus.done_o !== m_done || bus.err_o !== m_err || bus.err_code_o !== 2'(m_code)) begin n_bad++; $display("FAIL rnd_status r%0d c%0d: got done=%b err=%b code=%0d expected %0d/%0d/%0d", run, k, bus.done_o, bus.err_o, bus.err_code_o, m_done, m_err, m_code); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_stream();
    test_bubble_delay();
    test_field();
    test_seq_break();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mode_pipe_checker.md
Name: mode_pipe_checker

Overview:
- Downstream consumer of the per-cycle mode counter produced by the blocking/non-blocking regression stimulus.
- Delays the mode stream through a DEPTH-stage valid-tagged register pipe.
- Maintains a masked partial-write field register with last-write-wins semantics.
- Runs a sticky checker FSM that reports done or a coded error for $stop/$finish decisions in the test top.

Parameters:
- WIDTH, 8: mode word width.
- DEPTH, 3: delay-pipe stages; legal range 1..8.
- FIELD_W, 5: field register width.
- END_MODE, 4: mode value that triggers the final check. Elaboration error if END_MODE < DEPTH.

Ports:
- clk  in  1  sole clock, rising edge
- reset_l  in  1  asynchronous, active-low reset
- mode_i  in  WIDTH  incoming mode value
- mode_vld_i  in  1  mode_i valid this cycle
- fld_we_i  in  1  field write enable
- fld_mask_i  in  FIELD_W  per-bit write mask
- fld_data_i  in  FIELD_W  write data
- fld_chk_i  in  1  compare field against expected this cycle
- fld_exp_i  in  FIELD_W  expected field value
- mode_d_o  out  WIDTH  mode delayed by DEPTH cycles
- mode_d_vld_o  out  1  valid tag of mode_d_o
- fld_o  out  FIELD_W  current field register
- done_o  out  1  sticky pass
- err_o  out  1  sticky fail
- err_code_o  out  2  first error cause: 0 none, 1 field mismatch, 2 sequence break, 3 delay mismatch

Behaviour:
- Reset (async assert, sync-safe deassert): all pipe stages and valid tags 0; fld_o 0; done_o 0; err_o 0; err_code_o 0; FSM IDLE.
- Delay pipe:
  - Shifts every cycle, including bubbles (stage0 <= {mode_vld_i, mode_i}).
  - mode_d_o/mode_d_vld_o appear exactly DEPTH clocks after input.
  - Data in invalid stages is don't-care but must be held at 0.
- Field register:
  - When fld_we_i: fld <= (fld & ~fld_mask_i) | (fld_data_i & fld_mask_i). Unmasked bits hold.
  - Multiple writes in one cycle are impossible (single port).
  - Writes from successive cycles accumulate.
- Field check:
  - fld_chk_i compares the registered fld_o before this cycle's write against fld_exp_i.
  - A same-cycle write does not affect the comparison.
- FSM states and transitions:
  - IDLE -> RUN on first mode_vld_i; that value must be 0, else FAIL code 2.
  - RUN: each valid mode_i must equal last_valid+1 modulo 2^WIDTH (255->0 legal for WIDTH=8), else FAIL code 2. Invalid cycles are ignored and do not reset the expectation.
  - RUN, valid mode_i == END_MODE: require mode_d_vld_o=1 and mode_d_o == END_MODE-DEPTH in the same cycle. Pass -> DONE; fail -> FAIL code 3.
  - Field mismatch in RUN or IDLE -> FAIL code 1.
  - DONE and FAIL are absorbing until reset. Inputs are ignored by the checker; pipe and field keep operating.
- Simultaneous errors in one cycle: lowest nonzero code is latched.
- Completion with a simultaneous error yields FAIL, not DONE.
- done_o/err_o/err_code_o are registered: they assert one clock after the deciding edge.
- Reset mid-run: immediate return to the reset values above; the next valid must again be 0.

Decomposition:
- Package mode_pipe_pkg:
  - state enum {IDLE, RUN, DONE, FAIL}.
  - ERR_NONE/ERR_FIELD/ERR_SEQ/ERR_DELAY localparams (2-bit).
- Sub-module mode_delay_line:
  - Parameters WIDTH, DEPTH; ports clk, reset_l, in data+valid, out data+valid.
  - Instantiated once; the field register and FSM stay in the top.

Test Plan:
- Reset, then mode_vld_i=1 with mode_i=0,1,2,3,4 on consecutive edges -> mode_d_o=1 valid when mode_i=4; done_o=1 one clock later; err_o=0.
- Same stream with a bubble cycle between 2 and 3 -> at mode_i=4, mode_d_o=2 != 1 -> err_o=1, err_code_o=3.
- fld_we_i mask 5'b11000 data 5'b11000, next cycle mask 5'b00100 data 5'b00100, next mask 5'b00011 data 5'b00010, next mask 5'b01000 data 0 -> fld_o=5'b10110. fld_chk_i exp 5'b10110 -> no error; exp 5'b10111 -> err_code_o=1.
- Stream 0,1,3 -> err_code_o=2 one clock after 3 arrives. Later field mismatch -> code stays 2.
- Run to mode_i=2, assert reset_l=0 for a partial cycle -> all outputs 0 immediately. Restart stream at 5 -> err_code_o=2; restart at 0..4 -> done_o=1.
- WIDTH=8, END_MODE=4, first value 0, then 1..255, 0 wrap (END_MODE check disabled by forcing END_MODE hit only after wrap) -> no sequence error at 255->0.
